light_pos_buffer: RTL and testbench

Multi-light position front-end for the ray tracer core. It replaces the single-light L_LOC_X/Y/Z/vld path with NUM_LIGHTS independently addressable lights. Updates pass through a small FIFO into a shadow bank, then commit to the active bank the renderer reads. Commit happens either at frame start, which gives tear-free updates, or immediately, depending on the parameter SYNC_COMMIT.

---
 rtl/light_pos_buffer.sv | 93 +++++++++
 tb/tb_light_pos_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/light_pos_buffer.sv
// Multi-light position front-end for the ray tracer. Updates queue in a small FIFO,
// land in a shadow bank, then commit to the active bank on frame start or immediately.
module light_pos_buffer #(
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned NUM_LIGHTS  = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter bit          SYNC_COMMIT = 1'b1,
  parameter int unsigned IDX_W       = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [COORD_W-1:0]                wr_x,
  input  logic [COORD_W-1:0]                wr_y,
  input  logic [COORD_W-1:0]                wr_z,
  input  logic [IDX_W-1:0]                  wr_idx,
  input  logic                              wr_vld,
  output logic                              wr_rdy,
  input  logic                              lock,
  input  logic                              frame_start,
  output logic [NUM_LIGHTS*3*COORD_W-1:0]   act_pos,
  output logic [NUM_LIGHTS-1:0]             act_en,
  output logic                              pending,
  output logic [7:0]                        drop_cnt
);

  localparam int unsigned POS_W = 3 * COORD_W;
  localparam int unsigned ENT_W = IDX_W + POS_W;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [ENT_W-1:0]              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]              wr_ptr, rd_ptr;
  logic [NUM_LIGHTS*POS_W-1:0]   shadow;
  logic [NUM_LIGHTS-1:0]         shadow_en;

  logic             full, empty, push, pop, head_ok;
  logic [ENT_W-1:0] head;
  logic [IDX_W-1:0] head_idx;
  logic [POS_W-1:0] head_pos;

  // Full/empty from the pointer MSB; wr_rdy depends on registered pointers only.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_rdy   = !full;
  assign push     = wr_vld && !full;
  assign pop      = !empty && !lock && !(SYNC_COMMIT && frame_start);
  assign head     = mem[rd_ptr[AW-1:0]];
  assign head_idx = head[ENT_W-1 -: IDX_W];
  assign head_pos = head[POS_W-1:0];
  assign head_ok  = ({1'b0, head_idx} < (IDX_W+1)'(NUM_LIGHTS));

  // Storage array needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {wr_idx, wr_z, wr_y, wr_x};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      shadow    <= '0;
      shadow_en <= '0;
      act_pos   <= '0;
      act_en    <= '0;
      pending   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      if (pop && head_ok) begin
        shadow[int'(head_idx)*POS_W +: POS_W] <= head_pos;
        shadow_en[head_idx]                   <= 1'b1;
      end
      if (pop && !head_ok && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

      if (SYNC_COMMIT) begin
        // Drain is blocked on frame_start, so the commit sees the pre-edge shadow.
        if (frame_start) begin
          act_pos <= shadow;
          act_en  <= shadow_en;
          pending <= 1'b0;
        end else if (pop && head_ok) begin
          pending <= 1'b1;
        end
      end else if (pop && head_ok) begin
        act_pos[int'(head_idx)*POS_W +: POS_W] <= head_pos;
        act_en[head_idx]                       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_light_pos_buffer.sv
// Directed bench: instance a is frame-synchronous with 4 lights, instance b commits
// immediately with 3 lights (so idx 3 is out of range there). Inputs are shared.
module tb_light_pos_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  wr_x, wr_y, wr_z;
  logic [1:0]  wr_idx;
  logic        wr_vld, lock, frame_start;

  logic        a_rdy, a_pend;
  logic [119:0] a_pos;
  logic [3:0]  a_en;
  logic [7:0]  a_drop;

  logic        b_rdy, b_pend;
  logic [89:0] b_pos;
  logic [2:0]  b_en;
  logic [7:0]  b_drop;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  light_pos_buffer #(.COORD_W(10), .NUM_LIGHTS(4), .FIFO_DEPTH(4), .SYNC_COMMIT(1'b1)) dut_a (
    .clk(clk), .rst(rst), .wr_x(wr_x), .wr_y(wr_y), .wr_z(wr_z), .wr_idx(wr_idx),
    .wr_vld(wr_vld), .wr_rdy(a_rdy), .lock(lock), .frame_start(frame_start),
    .act_pos(a_pos), .act_en(a_en), .pending(a_pend), .drop_cnt(a_drop));

  light_pos_buffer #(.COORD_W(10), .NUM_LIGHTS(3), .FIFO_DEPTH(4), .SYNC_COMMIT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .wr_x(wr_x), .wr_y(wr_y), .wr_z(wr_z), .wr_idx(wr_idx),
    .wr_vld(wr_vld), .wr_rdy(b_rdy), .lock(lock), .frame_start(frame_start),
    .act_pos(b_pos), .act_en(b_en), .pending(b_pend), .drop_cnt(b_drop));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [29:0] pos(input logic [9:0] x, input logic [9:0] y, input logic [9:0] z);
    return {z, y, x};
  endfunction

  function automatic logic [29:0] a_slot(input int i);
    return a_pos[i*30 +: 30];
  endfunction

  function automatic logic [29:0] b_slot(input int i);
    return b_pos[i*30 +: 30];
  endfunction

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_vld = 1'b0; lock = 1'b0; frame_start = 1'b0;
    wr_x = '0; wr_y = '0; wr_z = '0; wr_idx = '0;
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic put(input logic [1:0] idx, input logic [9:0] x, input logic [9:0] y, input logic [9:0] z);
    wr_idx = idx; wr_x = x; wr_y = y; wr_z = z; wr_vld = 1'b1;
    tick();
    wr_vld = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    // 1: reset state, shadow write latency, frame-start commit
    do_reset();
    check("rst_rdy",  64'(a_rdy), 64'd1);
    check("rst_pos",  64'(a_pos == '0), 64'd1);
    check("rst_en",   64'(a_en), 64'd0);
    check("rst_pend", 64'(a_pend), 64'd0);
    check("rst_drop", 64'(a_drop), 64'd0);
    put(2'd2, 10'd5, 10'd6, 10'd7);
    check("t1_pend_k", 64'(a_pend), 64'd0);
    tick();
    check("t1_pend_k1", 64'(a_pend), 64'd1);
    check("t1_pos_pre", 64'(a_pos == '0), 64'd1);
    pulse_fs();
    check("t1_slot2", 64'(a_slot(2)), 64'(pos(10'd5, 10'd6, 10'd7)));
    check("t1_en",    64'(a_en), 64'b0100);
    check("t1_pend",  64'(a_pend), 64'd0);

    // 2: lock fills FIFO, fifth write held, then drains in order
    lock = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_idx = 2'(i % 4); wr_x = 10'(10 + i); wr_y = 10'(20 + i); wr_z = 10'(30 + i);
      wr_vld = 1'b1;
      check($sformatf("t2_rdy%0d", i), 64'(a_rdy), (i < 4) ? 64'd1 : 64'd0);
      tick();
    end
    check("t2_full_held", 64'(a_rdy), 64'd0);
    lock = 1'b0;
    tick();
    check("t2_rdy_after_pop", 64'(a_rdy), 64'd1);
    tick();
    wr_vld = 1'b0;
    tick(); tick(); tick(); tick();
    check("t2_pend", 64'(a_pend), 64'd1);
    pulse_fs();
    check("t2_slot0", 64'(a_slot(0)), 64'(pos(10'd14, 10'd24, 10'd34)));
    check("t2_slot1", 64'(a_slot(1)), 64'(pos(10'd11, 10'd21, 10'd31)));
    check("t2_slot3", 64'(a_slot(3)), 64'(pos(10'd13, 10'd23, 10'd33)));
    check("t2_en",    64'(a_en), 64'b1111);

    // 3: last write wins, then 12 writes wrapping the pointers
    put(2'd1, 10'd1, 10'd0, 10'd0);
    put(2'd1, 10'd9, 10'd0, 10'd0);
    tick(); tick();
    pulse_fs();
    check("t3_last_wins", 64'(a_slot(1)), 64'(pos(10'd9, 10'd0, 10'd0)));
    for (int i = 0; i < 12; i++) put(2'(i % 4), 10'(100 + i), 10'(i), 10'd0);
    tick(); tick(); tick();
    pulse_fs();
    for (int j = 0; j < 4; j++)
      check($sformatf("t3_wrap%0d", j), 64'(a_slot(j)), 64'(pos(10'(108 + j), 10'(8 + j), 10'd0)));

    // 4/6a: immediate commit on b, out-of-range index dropped, counter saturates
    do_reset();
    put(2'd0, 10'd4, 10'd4, 10'd4);
    check("t6_imm_k", 64'(b_slot(0)), 64'd0);
    tick();
    check("t6_imm_k1", 64'(b_slot(0)), 64'(pos(10'd4, 10'd4, 10'd4)));
    check("t6_imm_en", 64'(b_en), 64'b001);
    check("t6_imm_pend", 64'(b_pend), 64'd0);
    put(2'd3, 10'd77, 10'd77, 10'd77);
    tick();
    check("t4_drop1", 64'(b_drop), 64'd1);
    check("t4_slot0_kept", 64'(b_slot(0)), 64'(pos(10'd4, 10'd4, 10'd4)));
    check("t4_slots12", 64'(b_pos[89:30] == '0), 64'd1);
    check("t4_en_kept", 64'(b_en), 64'b001);
    wr_idx = 2'd3; wr_vld = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    wr_vld = 1'b0;
    tick(); tick();
    check("t4_drop_sat", 64'(b_drop), 64'd255);
    check("t4_rdy", 64'(b_rdy), 64'd1);

    // 5: frame_start while head is waiting commits the old value first
    do_reset();
    put(2'd0, 10'd1, 10'd0, 10'd0);
    tick();
    pulse_fs();
    check("t5_old", 64'(a_slot(0)), 64'(pos(10'd1, 10'd0, 10'd0)));
    put(2'd0, 10'd3, 10'd0, 10'd0);
    pulse_fs();
    check("t5_commit_old", 64'(a_slot(0)), 64'(pos(10'd1, 10'd0, 10'd0)));
    check("t5_pend0", 64'(a_pend), 64'd0);
    tick();
    check("t5_pend1", 64'(a_pend), 64'd1);
    check("t5_act_hold", 64'(a_slot(0)), 64'(pos(10'd1, 10'd0, 10'd0)));
    pulse_fs();
    check("t5_commit_new", 64'(a_slot(0)), 64'(pos(10'd3, 10'd0, 10'd0)));

    // frame_start under lock still commits
    put(2'd2, 10'd8, 10'd8, 10'd8);
    tick();
    lock = 1'b1;
    pulse_fs();
    check("t5_lock_commit", 64'(a_slot(2)), 64'(pos(10'd8, 10'd8, 10'd8)));
    lock = 1'b0;

    // 6b: async reset discards queued entries
    do_reset();
    put(2'd0, 10'd4, 10'd4, 10'd4);
    tick();
    lock = 1'b1;
    for (int i = 0; i < 4; i++) put(2'(i % 3), 10'(50 + i), 10'd1, 10'd2);
    check("t6_full", 64'(b_rdy), 64'd0);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_pos", 64'(b_pos == '0), 64'd1);
    check("t6_rst_en",  64'(b_en), 64'd0);
    check("t6_rst_rdy", 64'(b_rdy), 64'd1);
    check("t6_rst_a",   64'(a_pos == '0 && a_en == '0 && a_drop == '0), 64'd1);
    tick();
    rst = 1'b1;
    lock = 1'b0;
    tick(); tick(); tick();
    check("t6_no_stale", 64'(b_pos == '0), 64'd1);
    check("t6_no_stale_en", 64'(b_en), 64'd0);
    check("t6_rdy_after", 64'(b_rdy), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
